// File: rtl/float_to_fixed_pipe_if.sv
// Stream bundle for float_to_fixed_pipe: float input side and fixed-point result side with flags.
// slave is the converter, master is whatever feeds and drains it.
interface float_to_fixed_pipe_if #(
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_ovf;
    logic             out_nan;
    logic             out_uflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_nan, out_uflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_nan, out_uflow
    );
endinterface

// File: rtl/float_to_fixed_pipe.sv
// IEEE-754 single -> signed Q(IW).(FRAC_BITS) with sat/NaN/uflow flags; ROUND_NEAREST_EN selects half-away rounding.
// Latency: 2 cycles (decode, shift/saturate), 1 item per cycle sustained.
// Backpressure: stalling pipeline; in_ready = stage 1 can advance, outputs hold while out_valid && !out_ready.
module float_to_fixed_pipe #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic                 clk,
    input  logic                 reset,
    float_to_fixed_pipe_if.slave bus
);
    localparam int MW = OUT_W + 24;
    localparam logic signed [9:0] SH_BIAS = 10'(FRAC_BITS - 150);
    localparam logic signed [9:0] SH_MAX  = 10'(OUT_W);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    typedef struct packed {
        logic              sign;
        cls_t              cls;
        logic [23:0]       mant;
        logic signed [9:0] sh;
    } dec_t;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             ovf;
        logic             nan;
        logic             uflow;
    } res_t;

    logic s1_valid, s2_valid;
    logic s1_adv, s2_adv;
    dec_t s1_d, s1_q;
    res_t s2_d, s2_q;

    logic [7:0]  in_exp;
    logic [22:0] in_frac;

    assign s2_adv = !s2_valid || bus.out_ready;
    assign s1_adv = !s1_valid || s2_adv;

    assign in_exp  = bus.in_data[30:23];
    assign in_frac = bus.in_data[22:0];

    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.in_data[31];
        s1_d.mant = {1'b1, in_frac};
        s1_d.sh   = $signed({2'b00, in_exp}) + SH_BIAS;
        if (in_exp == 8'd0)
            s1_d.cls = (in_frac == '0) ? CLS_ZERO : CLS_DENORM;
        else if (in_exp == 8'hff)
            s1_d.cls = (in_frac == '0) ? CLS_INF : CLS_NAN;
        else
            s1_d.cls = CLS_NORMAL;
    end

    logic [MW-1:0]    mag_sh, mag;
    logic [9:0]       nsh;
    logic             huge;
    logic             ovf_mag;
    logic [OUT_W-1:0] sat_val;
`ifdef ROUND_NEAREST_EN
    logic [24:0]      rsh;
`else
    logic [23:0]      rsh;
`endif

    assign nsh = -s1_q.sh;

    // Any left shift past OUT_W puts the leading one above the wide intermediate: saturate outright.
    always_comb begin
        mag_sh = '0;
        huge   = 1'b0;
        rsh    = '0;
        mag    = '0;
        if (!s1_q.sh[9]) begin
            if (s1_q.sh > SH_MAX)
                huge = 1'b1;
            else
                mag_sh = MW'(s1_q.mant) << s1_q.sh[6:0];
            mag = mag_sh;
        end else begin
`ifdef ROUND_NEAREST_EN
            rsh    = {s1_q.mant, 1'b0} >> nsh;
            mag_sh = MW'(rsh[24:1]);
            mag    = mag_sh + MW'(rsh[0]);
`else
            rsh    = s1_q.mant >> nsh;
            mag_sh = MW'(rsh);
            mag    = mag_sh;
`endif
        end
    end

    assign ovf_mag = huge || (|mag[MW-1:OUT_W-1]);
    assign sat_val = s1_q.sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};

    always_comb begin
        s2_d = '0;
        case (s1_q.cls)
            CLS_NAN:    s2_d.nan   = 1'b1;
            CLS_INF: begin
                s2_d.ovf  = 1'b1;
                s2_d.data = sat_val;
            end
            CLS_DENORM: s2_d.uflow = 1'b1;
            CLS_NORMAL: begin
                if (ovf_mag) begin
                    s2_d.ovf  = 1'b1;
                    s2_d.data = sat_val;
                end else begin
                    s2_d.data  = s1_q.sign ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
                    s2_d.uflow = (mag == '0);
                end
            end
            default:    s2_d = '0;
        endcase
    end

    // Payload registers load only with a valid beat so idle-cycle X on in_data never reaches outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid)
                    s1_q <= s1_d;
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid)
                    s2_q <= s2_d;
            end
        end
    end

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_q.data;
    assign bus.out_ovf   = s2_q.ovf;
    assign bus.out_nan   = s2_q.nan;
    assign bus.out_uflow = s2_q.uflow;
endmodule

// File: tb/tb_float_to_fixed_pipe.sv
module tb_float_to_fixed_pipe;
    typedef struct {
        logic [63:0] data;
        logic [2:0]  flags;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    exp_t q[$];
    exp_t q16[$];

    float_to_fixed_pipe_if #(.OUT_W(32)) a();
    float_to_fixed_pipe_if #(.OUT_W(16)) b();

    float_to_fixed_pipe #(.OUT_W(32), .FRAC_BITS(30)) dut   (.clk(clk), .reset(reset), .bus(a));
    float_to_fixed_pipe #(.OUT_W(16), .FRAC_BITS(14)) dut16 (.clk(clk), .reset(reset), .bus(b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference built from the real value of the float; flags are {ovf, nan, uflow}.
    function automatic exp_t model(input logic [31:0] f, input int ow, input int fb);
        exp_t   r;
        int     e;
        real    m;
        longint v;
        e = int'(f[30:23]);
        r.data = '0;
        r.flags = 3'b000;
        r.cyc = cyc;
        if (e == 255 && f[22:0] != 0) begin
            r.flags = 3'b010;
            return r;
        end
        if (e == 0) begin
            if (f[22:0] != 0) r.flags = 3'b001;
            return r;
        end
        m = 0.0;
        if (e != 255) begin
            m = real'(int'({1'b1, f[22:0]})) * (2.0 ** (e - 150 + fb));
`ifdef ROUND_NEAREST_EN
            m = $floor(m + 0.5);
`else
            m = $floor(m);
`endif
        end
        if (e == 255 || m >= 2.0 ** (ow - 1)) begin
            r.flags = 3'b100;
            v = f[31] ? -(longint'(1) << (ow - 1)) : (longint'(1) << (ow - 1)) - 1;
        end else begin
            v = longint'(m);
            if (f[31]) v = -v;
            if (m == 0.0) r.flags = 3'b001;
        end
        r.data = 64'(v);
        return r;
    endfunction

    task automatic test_reset();
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (a.out_valid !== 1'b0 || a.out_data !== 32'h0 || {a.out_ovf, a.out_nan, a.out_uflow} !== 3'b000) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h flags=%b, expected 0/0/000",
                     a.out_valid, a.out_data, {a.out_ovf, a.out_nan, a.out_uflow});
        end
        checks++;
        if (a.in_ready !== 1'b1 || b.in_ready !== 1'b1 || b.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got in_ready=%b/%b out_valid16=%b, expected 1/1/0",
                     a.in_ready, b.in_ready, b.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_values();
        logic [31:0] vec [8];
        exp_t e;
        int sent = 0;
        int got = 0;
        vec = '{32'h3f800000, 32'hbf800000, 32'h3f000000, 32'h30800000,
                32'h3f47ae14, 32'h00000000, 32'h80000000, 32'h350637bd};
        for (int c = 0; c < 40 && got < 8; c++) begin
            a.out_ready = 1'b1;
            a.in_valid = (sent < 8);
            a.in_data = a.in_valid ? vec[sent] : 'x;
            #1;
            if (a.in_valid) begin
                checks++;
                if (a.in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL values_in_ready cycle %0d: got %b, expected 1", c, a.in_ready);
                end
            end
            if (a.out_valid && a.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL values_extra: unexpected output %h", a.out_data);
                end else begin
                    e = q.pop_front();
                    if (a.out_data !== e.data[31:0] || {a.out_ovf, a.out_nan, a.out_uflow} !== e.flags
                        || cyc - e.cyc != 2) begin
                        fails++;
                        $display("FAIL values item %0d: got data=%h flags=%b latency=%0d, expected data=%h flags=%b latency=2",
                                 got, a.out_data, {a.out_ovf, a.out_nan, a.out_uflow}, cyc - e.cyc,
                                 e.data[31:0], e.flags);
                    end
                end
                got++;
            end
            if (a.in_valid && a.in_ready) begin
                q.push_back(model(a.in_data, 32, 30));
                sent++;
            end
            @(negedge clk);
        end
        a.in_valid = 1'b0;
        checks++;
        if (got != 8 || q.size() != 0) begin
            fails++;
            $display("FAIL values_count: got %0d outputs with %0d pending, expected 8 and 0", got, q.size());
        end
    endtask

    task automatic test_specials();
        logic [31:0] vec [10];
        exp_t e;
        int sent = 0;
        int got = 0;
        vec = '{32'h40000000, 32'hc0400000, 32'h7f800000, 32'h7fc00000, 32'h00000001,
                32'h2f800000, 32'hc0000000, 32'hff800000, 32'h80000001, 32'h3fffffff};
        for (int c = 0; c < 50 && got < 10; c++) begin
            a.out_ready = 1'b1;
            a.in_valid = (sent < 10);
            a.in_data = a.in_valid ? vec[sent] : 'x;
            #1;
            if (a.out_valid && a.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL specials_extra: unexpected output %h", a.out_data);
                end else begin
                    e = q.pop_front();
                    if (a.out_data !== e.data[31:0] || {a.out_ovf, a.out_nan, a.out_uflow} !== e.flags) begin
                        fails++;
                        $display("FAIL specials item %0d: got data=%h flags=%b, expected data=%h flags=%b",
                                 got, a.out_data, {a.out_ovf, a.out_nan, a.out_uflow}, e.data[31:0], e.flags);
                    end
                end
                got++;
            end
            if (a.in_valid && a.in_ready) begin
                q.push_back(model(a.in_data, 32, 30));
                sent++;
            end
            @(negedge clk);
        end
        a.in_valid = 1'b0;
        checks++;
        if (got != 10 || q.size() != 0) begin
            fails++;
            $display("FAIL specials_count: got %0d outputs with %0d pending, expected 10 and 0", got, q.size());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] vec [5];
        logic [31:0] held = '0;
        exp_t e;
        int sent = 0;
        int got = 0;
        vec = '{32'h3f800000, 32'hbf800000, 32'h3f000000, 32'h3e800000, 32'h40000000};
        for (int c = 0; c < 40 && got < 5; c++) begin
            a.out_ready = !(c >= 2 && c <= 5);
            a.in_valid = (sent < 5);
            a.in_data = a.in_valid ? vec[sent] : 'x;
            #1;
            if (c >= 2 && c <= 5) begin
                checks++;
                if (a.in_ready !== 1'b0 || a.out_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL bp_stall cycle %0d: got in_ready=%b out_valid=%b, expected 0/1",
                             c, a.in_ready, a.out_valid);
                end
            end
            if (c == 2) held = a.out_data;
            if (c >= 3 && c <= 5) begin
                checks++;
                if (a.out_data !== held) begin
                    fails++;
                    $display("FAIL bp_stable cycle %0d: got %h, expected %h", c, a.out_data, held);
                end
            end
            if (a.out_valid && a.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL bp_extra: unexpected output %h", a.out_data);
                end else begin
                    e = q.pop_front();
                    if (a.out_data !== e.data[31:0] || {a.out_ovf, a.out_nan, a.out_uflow} !== e.flags) begin
                        fails++;
                        $display("FAIL bp item %0d: got data=%h flags=%b, expected data=%h flags=%b",
                                 got, a.out_data, {a.out_ovf, a.out_nan, a.out_uflow}, e.data[31:0], e.flags);
                    end
                end
                got++;
            end
            if (a.in_valid && a.in_ready) begin
                q.push_back(model(a.in_data, 32, 30));
                sent++;
            end
            @(negedge clk);
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (got != 5 || q.size() != 0 || a.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_count: got %0d outputs, %0d pending, out_valid=%b; expected 5, 0, 0",
                     got, q.size(), a.out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_random_stream();
        exp_t e;
        logic [31:0] f;
        int sent = 0;
        int got = 0;
        for (int c = 0; c < 4000 && got < 300; c++) begin
            a.out_ready = ($urandom_range(0, 3) != 0);
            a.in_valid = (sent < 300) && ($urandom_range(0, 2) != 0);
            f = $urandom;
            case ($urandom_range(0, 9))
                0:       f[30:23] = 8'd0;
                1:       f[30:23] = 8'hff;
                default: f[30:23] = 8'($urandom_range(95, 135));
            endcase
            a.in_data = a.in_valid ? f : 'x;
            #1;
            if (a.out_valid && a.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL random_extra: unexpected output %h", a.out_data);
                end else begin
                    e = q.pop_front();
                    if (a.out_data !== e.data[31:0] || {a.out_ovf, a.out_nan, a.out_uflow} !== e.flags) begin
                        fails++;
                        $display("FAIL random item %0d: got data=%h flags=%b, expected data=%h flags=%b",
                                 got, a.out_data, {a.out_ovf, a.out_nan, a.out_uflow}, e.data[31:0], e.flags);
                    end
                end
                got++;
            end
            if (a.in_valid && a.in_ready) begin
                q.push_back(model(a.in_data, 32, 30));
                sent++;
            end
            @(negedge clk);
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        checks++;
        if (got != 300 || q.size() != 0) begin
            fails++;
            $display("FAIL random_count: got %0d outputs with %0d pending, expected 300 and 0", got, q.size());
        end
    endtask

    task automatic test_reset_inflight();
        a.out_ready = 1'b1;
        a.in_valid = 1'b1;
        a.in_data = 32'h3f800000;
        @(negedge clk);
        a.in_data = 32'hbf800000;
        @(negedge clk);
        a.in_valid = 1'b0;
        a.in_data = 'x;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_flush: got out_valid=%b in_ready=%b, expected 0/1", a.out_valid, a.in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (a.out_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_stale cycle %0d: got out_valid=%b data=%h, expected no output",
                         c, a.out_valid, a.out_data);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_param_sweep();
        logic [31:0] vec [5];
        exp_t e;
        int sent = 0;
        int got = 0;
        vec = '{32'h3f800000, 32'h3fc00000, 32'h40000000, 32'hbf800000, 32'h38800000};
        for (int c = 0; c < 30 && got < 5; c++) begin
            b.out_ready = 1'b1;
            b.in_valid = (sent < 5);
            b.in_data = b.in_valid ? vec[sent] : 'x;
            #1;
            if (b.out_valid && b.out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    fails++;
                    $display("FAIL sweep_extra: unexpected output %h", b.out_data);
                end else begin
                    e = q16.pop_front();
                    if (b.out_data !== e.data[15:0] || {b.out_ovf, b.out_nan, b.out_uflow} !== e.flags) begin
                        fails++;
                        $display("FAIL sweep item %0d: got data=%h flags=%b, expected data=%h flags=%b",
                                 got, b.out_data, {b.out_ovf, b.out_nan, b.out_uflow}, e.data[15:0], e.flags);
                    end
                end
                got++;
            end
            if (b.in_valid && b.in_ready) begin
                q16.push_back(model(b.in_data, 16, 14));
                sent++;
            end
            @(negedge clk);
        end
        b.in_valid = 1'b0;
        checks++;
        if (got != 5 || q16.size() != 0) begin
            fails++;
            $display("FAIL sweep_count: got %0d outputs with %0d pending, expected 5 and 0", got, q16.size());
        end
    endtask

    initial begin
        test_reset();
        test_values();
        test_specials();
        test_backpressure();
        test_random_stream();
        test_reset_inflight();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
